// File: rtl/uart_cmd_pkg.sv
// Shared constants and types for the UART command controller: command/reply
// byte codes, the controller state encoding and the reply lookup.
package uart_cmd_pkg;

  localparam logic [7:0] CMD_LED   = 8'h4C;  // 'L' + argument byte
  localparam logic [7:0] CMD_READ  = 8'h52;  // 'R'
  localparam logic [7:0] CMD_CLEAR = 8'h43;  // 'C'
  localparam logic [7:0] RPL_OK    = 8'h4B;  // 'K'
  localparam logic [7:0] RPL_ERR   = 8'h3F;  // '?'

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GET_ARG = 2'd1,
    ST_SEND    = 2'd2
  } state_t;

  function automatic logic is_known_cmd(input logic [7:0] cmd);
    return (cmd == CMD_LED) || (cmd == CMD_READ) || (cmd == CMD_CLEAR);
  endfunction

  // Reply for a first byte accepted in IDLE; 'L' is overwritten once its argument lands.
  function automatic logic [7:0] reply_for(input logic [7:0] cmd, input logic [7:0] led_val);
    logic [7:0] r;
    case (cmd)
      CMD_READ:           r = led_val;
      CMD_LED, CMD_CLEAR: r = RPL_OK;
      default:            r = RPL_ERR;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Byte-level link between the serial rx/tx blocks and the command controller.
interface uart_cmd_ctrl_if;
  // rx_new is a one-cycle strobe qualifying rx_data (no backpressure); tx_new is a
  // one-cycle strobe qualifying tx_data, only issued after tx_busy was sampled low.
  logic [7:0] rx_data;
  logic       rx_new;
  logic [7:0] tx_data;
  logic       tx_new;
  logic       tx_busy;

  modport master (output rx_data, output rx_new, output tx_busy,
                  input  tx_data, input  tx_new);
  modport slave  (input  rx_data, input  rx_new, input  tx_busy,
                  output tx_data, output tx_new);
endinterface

// File: rtl/cmd_timeout.sv
// Saturating cycle counter guarding the wait for a command argument byte.
module cmd_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      count_q <= '0;
    end else if (count_q != LIMIT) begin
      count_q <= count_q + CW'(1);
    end
  end

  // High during the TIMEOUT_CYCLES-th uncleared cycle, so the owner leaves on that edge.
  assign expired = (count_q >= LIMIT - CW'(1));

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Byte command decoder between the UART rx/tx and the user LEDs: 'L'+arg sets
// the LEDs, 'R' reads them back, 'C' clears them; each command gets one reply byte.
module uart_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  uart_cmd_ctrl_if.slave        bus,
  output logic [7:0]            led,
  output logic                  err,
  output state_t                state_dbg
);

  state_t     state_q, state_d;
  logic [7:0] led_q, reply_q, tx_data_q;
  logic       tx_new_q, err_q;
  logic       accept_cmd, take_arg, launch, err_set;
  logic       tmo_clear, tmo_expired;

  cmd_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (tmo_clear),
    .expired (tmo_expired)
  );

  assign tmo_clear = (state_q != ST_GET_ARG);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = ST_IDLE;
    case (state_q)
      ST_IDLE: begin
        if (!bus.rx_new)                 state_d = ST_IDLE;
        else if (bus.rx_data == CMD_LED) state_d = ST_GET_ARG;
        else                             state_d = ST_SEND;
      end
      ST_GET_ARG: begin
        if (bus.rx_new)       state_d = ST_SEND;
        else if (tmo_expired) state_d = ST_IDLE;
        else                  state_d = ST_GET_ARG;
      end
      ST_SEND:  state_d = bus.tx_busy ? ST_SEND : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // An arriving argument wins over a timeout expiring in the same cycle.
  always_comb begin
    accept_cmd = 1'b0;
    take_arg   = 1'b0;
    launch     = 1'b0;
    err_set    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        accept_cmd = bus.rx_new;
        err_set    = bus.rx_new && !is_known_cmd(bus.rx_data);
      end
      ST_GET_ARG: begin
        take_arg = bus.rx_new;
        err_set  = !bus.rx_new && tmo_expired;
      end
      ST_SEND: begin
        launch  = !bus.tx_busy;
        err_set = bus.rx_new;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led_q     <= 8'h00;
      reply_q   <= 8'h00;
      tx_data_q <= 8'h00;
      tx_new_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      tx_new_q <= launch;
      err_q    <= err_set;
      if (launch) tx_data_q <= reply_q;
      if (accept_cmd) begin
        reply_q <= reply_for(bus.rx_data, led_q);
        if (bus.rx_data == CMD_CLEAR) led_q <= 8'h00;
      end
      if (take_arg) begin
        led_q   <= bus.rx_data;
        reply_q <= RPL_OK;
      end
    end
  end

  assign bus.tx_data = tx_data_q;
  assign bus.tx_new  = tx_new_q;
  assign led         = led_q;
  assign err         = err_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: a command table plus hand sequences for
// transmitter backpressure, argument timeout and reset in the middle of a command.
module tb_uart_cmd_ctrl;
  import uart_cmd_pkg::*;

  localparam int unsigned TMO = 16;

  typedef struct {
    logic [7:0] cmd;
    logic       has_arg;
    logic [7:0] arg;
    logic [7:0] exp_reply;
    logic [7:0] exp_led;
    logic       exp_err;
  } vec_t;

  logic   clk;
  logic   rst_n;
  logic [7:0] led;
  logic   err;
  state_t state_dbg;

  uart_cmd_ctrl_if bus();

  uart_cmd_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .led       (led),
    .err       (err),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int tx_cnt   = 0;
  int err_cnt  = 0;
  logic busy_rec = 1'b0;
  logic prev_tx  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] e;
    if (err) err_cnt++;
    if (bus.tx_new) begin
      tx_cnt++;
      check("tx_after_busy", busy_rec, 1'b0);
      check("tx_new_width", prev_tx, 1'b0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_tx: got %0h expected no reply", bus.tx_data);
      end else begin
        e = exp_q.pop_front();
        check("tx_data", bus.tx_data, e);
      end
    end
    prev_tx  = bus.tx_new;
    busy_rec = bus.tx_busy;
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data = b;
    bus.rx_new  = 1'b1;
    cyc();
    bus.rx_new  = 1'b0;
  endtask

  function automatic vec_t mk(input logic [7:0] cmd, input logic has_arg, input logic [7:0] arg,
                              input logic [7:0] rep, input logic [7:0] l, input logic e);
    vec_t v;
    v.cmd = cmd; v.has_arg = has_arg; v.arg = arg;
    v.exp_reply = rep; v.exp_led = l; v.exp_err = e;
    return v;
  endfunction

  // ---------------- test ----------------
  vec_t vecs[14];
  logic [7:0] cur_led;
  logic [7:0] rnd_led, rnd_bad;
  int tx0, e0;
  logic early;

  initial begin
    rnd_led = 8'($urandom_range(0, 255));
    rnd_bad = 8'($urandom_range(0, 63));
    vecs[0]  = mk(CMD_LED,   1'b1, 8'hA5, RPL_OK,  8'hA5, 1'b0);
    vecs[1]  = mk(CMD_READ,  1'b0, 8'h00, 8'hA5,   8'hA5, 1'b0);
    vecs[2]  = mk(CMD_CLEAR, 1'b0, 8'h00, RPL_OK,  8'h00, 1'b0);
    vecs[3]  = mk(8'h5A,     1'b0, 8'h00, RPL_ERR, 8'h00, 1'b1);
    vecs[4]  = mk(CMD_LED,   1'b1, 8'h3C, RPL_OK,  8'h3C, 1'b0);
    vecs[5]  = mk(CMD_READ,  1'b0, 8'h00, 8'h3C,   8'h3C, 1'b0);
    vecs[6]  = mk(8'h00,     1'b0, 8'h00, RPL_ERR, 8'h3C, 1'b1);
    vecs[7]  = mk(rnd_bad,   1'b0, 8'h00, RPL_ERR, 8'h3C, 1'b1);
    vecs[8]  = mk(CMD_LED,   1'b1, 8'hFF, RPL_OK,  8'hFF, 1'b0);
    vecs[9]  = mk(CMD_READ,  1'b0, 8'h00, 8'hFF,   8'hFF, 1'b0);
    vecs[10] = mk(CMD_LED,   1'b1, CMD_READ, RPL_OK, CMD_READ, 1'b0);
    vecs[11] = mk(CMD_READ,  1'b0, 8'h00, CMD_READ, CMD_READ, 1'b0);
    vecs[12] = mk(CMD_LED,   1'b1, rnd_led, RPL_OK, rnd_led, 1'b0);
    vecs[13] = mk(CMD_READ,  1'b0, 8'h00, rnd_led, rnd_led, 1'b0);

    rst_n       = 1'b0;
    bus.rx_data = 8'h00;
    bus.rx_new  = 1'b0;
    bus.tx_busy = 1'b0;
    repeat (3) cyc();
    @(negedge clk);
    check("rst_led", led, 8'h00);
    check("rst_tx_data", bus.tx_data, 8'h00);
    check("rst_tx_new", bus.tx_new, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_state", state_dbg, ST_IDLE);
    cyc();
    rst_n = 1'b1;

    // Table: first command goes in the very first cycle after reset release.
    for (int i = 0; i < 14; i++) begin
      e0 = err_cnt;
      exp_q.push_back(vecs[i].exp_reply);
      send_byte(vecs[i].cmd);
      if (vecs[i].has_arg) send_byte(vecs[i].arg);
      @(negedge clk);
      check("lat_n1_quiet", bus.tx_new, 1'b0);
      @(negedge clk);
      check("lat_n2_pulse", bus.tx_new, 1'b1);
      check("vec_led", led, vecs[i].exp_led);
      cyc();
      @(negedge clk);
      check("tx_data_hold", bus.tx_data, vecs[i].exp_reply);
      check("vec_idle", state_dbg, ST_IDLE);
      cyc();
      check("vec_err", err_cnt - e0, 32'(vecs[i].exp_err));
    end
    cur_led = rnd_led;

    // Transmitter busy for 50 cycles; a byte arriving meanwhile is dropped.
    tx0 = tx_cnt;
    e0  = err_cnt;
    bus.tx_busy = 1'b1;
    exp_q.push_back(cur_led);
    send_byte(CMD_READ);
    for (int i = 0; i < 49; i++) begin
      if (i == 10) send_byte(8'h77);
      else         cyc();
    end
    check("busy_hold", tx_cnt - tx0, 0);
    bus.tx_busy = 1'b0;
    for (int i = 0; i < 8 && tx_cnt == tx0; i++) @(negedge clk);
    cyc();
    repeat (3) cyc();
    check("busy_single", tx_cnt - tx0, 1);
    check("busy_drop_err", err_cnt - e0, 1);
    check("busy_led", led, cur_led);
    check("busy_idle", state_dbg, ST_IDLE);

    // Argument timeout: 'L' then silence.
    tx0 = tx_cnt;
    e0  = err_cnt;
    early = 1'b0;
    send_byte(CMD_LED);
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      if (i < 17 && err) early = 1'b1;
      if (i == 16) check("tmo_still_wait", state_dbg, ST_GET_ARG);
      if (i == 17) begin
        check("tmo_err", err, 1'b1);
        check("tmo_idle", state_dbg, ST_IDLE);
      end
    end
    check("tmo_no_early_err", early, 1'b0);
    cyc();
    check("tmo_no_reply", tx_cnt - tx0, 0);
    check("tmo_led", led, cur_led);
    check("tmo_err_count", err_cnt - e0, 1);
    exp_q.push_back(cur_led);
    send_byte(CMD_READ);
    repeat (4) cyc();
    check("tmo_next_read", tx_cnt - tx0, 1);

    // Reset for one cycle while waiting for an argument.
    tx0 = tx_cnt;
    send_byte(CMD_LED);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_led", led, 8'h00);
    check("mid_rst_tx_data", bus.tx_data, 8'h00);
    check("mid_rst_tx_new", bus.tx_new, 1'b0);
    check("mid_rst_err", err, 1'b0);
    check("mid_rst_state", state_dbg, ST_IDLE);
    cyc();
    repeat (5) cyc();
    check("mid_rst_no_tx", tx_cnt - tx0, 0);
    exp_q.push_back(RPL_OK);
    send_byte(CMD_LED);
    send_byte(8'h81);
    repeat (4) cyc();
    check("post_rst_led", led, 8'h81);
    check("post_rst_reply", tx_cnt - tx0, 1);

    check("sb_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
